// File: rtl/instr_decoder.sv
// Instruction register plus registered one-hot MIPS decode and field capture.
// Optional macro DECODER_STATS_EN adds decode and illegal-decode counters.
module instr_decoder #(
   parameter logic [31:0] IR_RESET = 32'h00000000,
   parameter int          COUNT_W  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ir_in,
   input  logic                decode_ena,
   input  logic [31:0]         instr_in,
   output logic [31:0]         ir_out,
   output logic [53:0]         decoded_instr,
   output logic                decoded_valid,
   output logic                illegal_instr,
   output logic [4:0]          rs,
   output logic [4:0]          rt,
   output logic [4:0]          rd,
   output logic [4:0]          shamt,
   output logic [15:0]         imm16,
   output logic [25:0]         target26
`ifdef DECODER_STATS_EN
   ,
   output logic [COUNT_W-1:0]  instr_count,
   output logic [COUNT_W-1:0]  illegal_count
`endif
);

   logic [31:0] ir_q, ir_d;
   logic [53:0] dec_q, dec_d;
   logic        valid_q, valid_d;
   logic        illegal_q, illegal_d;
   logic [25:0] field_q, field_d;   // every datapath field is a slice of instr[25:0]
   logic [31:0] src;
   logic [53:0] onehot;
   logic [5:0]  op, funct;
   logic [4:0]  src_rs, src_rt;

   // Bypass lets a same-cycle IR load and decode see the incoming word.
   assign src    = ir_in ? instr_in : ir_q;
   assign op     = src[31:26];
   assign funct  = src[5:0];
   assign src_rs = src[25:21];
   assign src_rt = src[20:16];

   always_comb begin
      onehot = '0;
      case (op)
         6'h00: begin
            case (funct)
               6'h20: onehot[0]  = 1'b1;
               6'h21: onehot[1]  = 1'b1;
               6'h22: onehot[2]  = 1'b1;
               6'h23: onehot[3]  = 1'b1;
               6'h24: onehot[4]  = 1'b1;
               6'h25: onehot[5]  = 1'b1;
               6'h26: onehot[6]  = 1'b1;
               6'h27: onehot[7]  = 1'b1;
               6'h2A: onehot[8]  = 1'b1;
               6'h2B: onehot[9]  = 1'b1;
               6'h00: onehot[10] = 1'b1;
               6'h02: onehot[11] = 1'b1;
               6'h03: onehot[12] = 1'b1;
               6'h04: onehot[13] = 1'b1;
               6'h06: onehot[14] = 1'b1;
               6'h07: onehot[15] = 1'b1;
               6'h08: onehot[16] = 1'b1;
               6'h1B: onehot[32] = 1'b1;
               6'h09: onehot[34] = 1'b1;
               6'h10: onehot[36] = 1'b1;
               6'h12: onehot[37] = 1'b1;
               6'h0D: onehot[44] = 1'b1;
               6'h0C: onehot[45] = 1'b1;
               6'h34: onehot[46] = 1'b1;
               6'h11: onehot[48] = 1'b1;
               6'h13: onehot[49] = 1'b1;
               6'h19: onehot[51] = 1'b1;
               6'h1A: onehot[52] = 1'b1;
               default: ;
            endcase
         end
         6'h1C: begin
            if (funct == 6'h20) onehot[31] = 1'b1;
            if (funct == 6'h02) onehot[50] = 1'b1;
         end
         6'h10: begin
            if (src_rs == 5'b00000) onehot[35] = 1'b1;
            if (src_rs == 5'b00100) onehot[47] = 1'b1;
            if (src_rs == 5'b10000 && funct == 6'h18) onehot[33] = 1'b1;
         end
         6'h01: if (src_rt == 5'b00001) onehot[53] = 1'b1;
         6'h08: onehot[17] = 1'b1;
         6'h09: onehot[18] = 1'b1;
         6'h0C: onehot[19] = 1'b1;
         6'h0D: onehot[20] = 1'b1;
         6'h0E: onehot[21] = 1'b1;
         6'h0F: onehot[22] = 1'b1;
         6'h23: onehot[23] = 1'b1;
         6'h2B: onehot[24] = 1'b1;
         6'h04: onehot[25] = 1'b1;
         6'h05: onehot[26] = 1'b1;
         6'h0A: onehot[27] = 1'b1;
         6'h0B: onehot[28] = 1'b1;
         6'h02: onehot[29] = 1'b1;
         6'h03: onehot[30] = 1'b1;
         6'h21: onehot[38] = 1'b1;
         6'h20: onehot[39] = 1'b1;
         6'h24: onehot[40] = 1'b1;
         6'h25: onehot[41] = 1'b1;
         6'h28: onehot[42] = 1'b1;
         6'h29: onehot[43] = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      ir_d      = ir_q;
      dec_d     = dec_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      field_d   = field_q;
      if (ir_in) ir_d = instr_in;
      if (decode_ena) begin
         dec_d     = onehot;
         valid_d   = 1'b1;
         illegal_d = (onehot == '0);
         field_d   = src[25:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q      <= IR_RESET;
         dec_q     <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         field_q   <= '0;
      end else begin
         ir_q      <= ir_d;
         dec_q     <= dec_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         field_q   <= field_d;
      end
   end

   assign ir_out        = ir_q;
   assign decoded_instr = dec_q;
   assign decoded_valid = valid_q;
   assign illegal_instr = illegal_q;
   assign rs            = field_q[25:21];
   assign rt            = field_q[20:16];
   assign rd            = field_q[15:11];
   assign shamt         = field_q[10:6];
   assign imm16         = field_q[15:0];
   assign target26      = field_q;

`ifdef DECODER_STATS_EN
   logic [COUNT_W-1:0] icnt_q, icnt_d, lcnt_q, lcnt_d;

   always_comb begin
      icnt_d = icnt_q;
      lcnt_d = lcnt_q;
      if (decode_ena) begin
         icnt_d = icnt_q + COUNT_W'(1);
         if (onehot == '0) lcnt_d = lcnt_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         icnt_q <= '0;
         lcnt_q <= '0;
      end else begin
         icnt_q <= icnt_d;
         lcnt_q <= lcnt_d;
      end
   end

   assign instr_count   = icnt_q;
   assign illegal_count = lcnt_q;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed scenarios plus randomized
// traffic against a table-driven reference model of the MIPS decode.
module tb_instr_decoder;

   logic        clk = 1'b0;
   logic        rst, ir_in, decode_ena;
   logic [31:0] instr_in;
   logic [31:0] ir_out;
   logic [53:0] decoded_instr;
   logic        decoded_valid, illegal_instr;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [25:0] target26;
`ifdef DECODER_STATS_EN
   logic [31:0] instr_count, illegal_count;
`endif

   int errors = 0;
   int checks = 0;

   instr_decoder dut (
      .clk(clk), .rst(rst), .ir_in(ir_in), .decode_ena(decode_ena),
      .instr_in(instr_in), .ir_out(ir_out), .decoded_instr(decoded_instr),
      .decoded_valid(decoded_valid), .illegal_instr(illegal_instr),
      .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16),
      .target26(target26)
`ifdef DECODER_STATS_EN
      , .instr_count(instr_count), .illegal_count(illegal_count)
`endif
   );

   always #5 clk = ~clk;

   // Encoding table indexed by one-hot bit. Selector: 0 opcode only,
   // 1 opcode+funct, 2 opcode+rs, 3 opcode+rs=10000+funct, 4 opcode+rt.
   localparam logic [5:0] OP_T [54] = '{
      6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,
      6'h00,6'h08,6'h09,6'h0C,6'h0D,6'h0E,6'h0F,6'h23,6'h2B,6'h04,6'h05,6'h0A,6'h0B,6'h02,6'h03,6'h1C,
      6'h00,6'h10,6'h00,6'h10,6'h00,6'h00,6'h21,6'h20,6'h24,6'h25,6'h28,6'h29,6'h00,6'h00,6'h00,6'h10,
      6'h00,6'h00,6'h1C,6'h00,6'h00,6'h01};
   localparam int SEL_T [54] = '{
      1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,
      1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,
      1,3,1,2,1,1,0,0,0,0,0,0,1,1,1,2,
      1,1,1,1,1,4};
   localparam logic [5:0] KEY_T [54] = '{
      6'h20,6'h21,6'h22,6'h23,6'h24,6'h25,6'h26,6'h27,6'h2A,6'h2B,6'h00,6'h02,6'h03,6'h04,6'h06,6'h07,
      6'h08,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h20,
      6'h1B,6'h18,6'h09,6'h00,6'h10,6'h12,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h0D,6'h0C,6'h34,6'h04,
      6'h11,6'h13,6'h02,6'h19,6'h1A,6'h01};

   function automatic logic [53:0] ref_decode(input logic [31:0] w);
      logic [53:0] r = '0;
      for (int k = 0; k < 54; k++) begin
         logic hit;
         hit = (w[31:26] == OP_T[k]);
         case (SEL_T[k])
            1: hit = hit && (w[5:0] == KEY_T[k]);
            2: hit = hit && (w[25:21] == KEY_T[k][4:0]);
            3: hit = hit && (w[25:21] == 5'h10) && (w[5:0] == KEY_T[k]);
            4: hit = hit && (w[20:16] == KEY_T[k][4:0]);
            default: ;
         endcase
         if (hit) r[k] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [31:0] legal_word(input int k);
      logic [31:0] w = $urandom;
      w[31:26] = OP_T[k];
      case (SEL_T[k])
         1: w[5:0] = KEY_T[k];
         2: w[25:21] = KEY_T[k][4:0];
         3: begin w[25:21] = 5'h10; w[5:0] = KEY_T[k]; end
         4: w[20:16] = KEY_T[k][4:0];
         default: ;
      endcase
      return w;
   endfunction

   // Reference state
   logic [31:0] m_ir, m_src;
   logic [53:0] m_dec;
   logic        m_valid, m_ill;
   int unsigned m_icnt, m_lcnt;

   task automatic drive(input logic r, input logic ir, input logic de, input logic [31:0] w);
      logic [31:0] s;
      rst = r; ir_in = ir; decode_ena = de; instr_in = w;
      @(posedge clk);
      #1;
      if (r) begin
         m_ir = 32'h0; m_src = 32'h0; m_dec = '0; m_valid = 1'b0; m_ill = 1'b0;
         m_icnt = 0; m_lcnt = 0;
      end else begin
         s = ir ? w : m_ir;
         if (ir) m_ir = w;
         if (de) begin
            m_dec = ref_decode(s); m_src = s; m_valid = 1'b1; m_ill = (m_dec == '0);
            m_icnt++;
            if (m_dec == '0) m_lcnt++;
         end
      end
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b1, 1'b1, 32'h00221820);
      drive(1'b1, 1'b1, 1'b1, 32'h00221820);
      checks++;
      if ({ir_out, decoded_instr, decoded_valid, illegal_instr} !== {32'h0, 54'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got ir=%h dec=%h v=%b ill=%b exp all zero", ir_out, decoded_instr, decoded_valid, illegal_instr);
      end
      checks++;
      if ({rs, rt, rd, shamt, imm16, target26} !== '0) begin
         errors++;
         $display("FAIL reset_fields got target26=%h rd=%h shamt=%h exp 0", target26, rd, shamt);
      end
`ifdef DECODER_STATS_EN
      checks++;
      if ({instr_count, illegal_count} !== 64'h0) begin
         errors++;
         $display("FAIL reset_counts got %0d/%0d exp 0/0", instr_count, illegal_count);
      end
`endif
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (decoded_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid_idle got %b exp 0", decoded_valid);
      end
   endtask

   task automatic test_bypass;
      drive(1'b0, 1'b1, 1'b1, 32'h00221820);
      checks++;
      if (decoded_instr !== 54'h1 || decoded_valid !== 1'b1 || illegal_instr !== 1'b0) begin
         errors++;
         $display("FAIL bypass_add got dec=%h v=%b ill=%b exp dec=1 v=1 ill=0", decoded_instr, decoded_valid, illegal_instr);
      end
      checks++;
      if ({rs, rt, rd} !== {5'd1, 5'd2, 5'd3} || ir_out !== 32'h00221820) begin
         errors++;
         $display("FAIL bypass_fields got rs=%0d rt=%0d rd=%0d ir=%h exp 1 2 3 00221820", rs, rt, rd, ir_out);
      end
   endtask

   task automatic test_jr_lh;
      drive(1'b0, 1'b1, 1'b1, 32'h03E00008);
      checks++;
      if (decoded_instr !== (54'h1 << 16) || rs !== 5'd31 || illegal_instr !== 1'b0) begin
         errors++;
         $display("FAIL jr got dec=%h rs=%0d ill=%b exp bit16 rs=31 ill=0", decoded_instr, rs, illegal_instr);
      end
      drive(1'b0, 1'b1, 1'b1, 32'h84A80004);
      checks++;
      if (decoded_instr !== (54'h1 << 38) || rs !== 5'd5 || rt !== 5'd8 || imm16 !== 16'h0004) begin
         errors++;
         $display("FAIL lh got dec=%h rs=%0d rt=%0d imm=%h exp bit38 5 8 0004", decoded_instr, rs, rt, imm16);
      end
   endtask

   task automatic test_illegal;
      drive(1'b0, 1'b1, 1'b1, 32'hFC000000);
      checks++;
      if (decoded_instr !== 54'h0 || illegal_instr !== 1'b1 || decoded_valid !== 1'b1) begin
         errors++;
         $display("FAIL illegal got dec=%h ill=%b v=%b exp 0 1 1", decoded_instr, illegal_instr, decoded_valid);
      end
`ifdef DECODER_STATS_EN
      checks++;
      if (illegal_count !== 32'd1 || instr_count !== 32'd4) begin
         errors++;
         $display("FAIL illegal_counts got instr=%0d ill=%0d exp 4 1", instr_count, illegal_count);
      end
`endif
   endtask

   task automatic test_hold_split;
      drive(1'b0, 1'b1, 1'b0, 32'h0C000010);
      checks++;
      if (ir_out !== 32'h0C000010 || decoded_instr !== 54'h0 || illegal_instr !== 1'b1) begin
         errors++;
         $display("FAIL split_load got ir=%h dec=%h ill=%b exp 0C000010 0 1", ir_out, decoded_instr, illegal_instr);
      end
      drive(1'b0, 1'b0, 1'b1, 32'hFC000000);
      checks++;
      if (decoded_instr !== (54'h1 << 30) || target26 !== 26'h0000010 || illegal_instr !== 1'b0) begin
         errors++;
         $display("FAIL split_jal got dec=%h t26=%h ill=%b exp bit30 0000010 0", decoded_instr, target26, illegal_instr);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, $urandom);
         checks++;
         if (decoded_instr !== (54'h1 << 30) || target26 !== 26'h0000010 || ir_out !== 32'h0C000010) begin
            errors++;
            $display("FAIL hold_%0d got dec=%h t26=%h ir=%h exp bit30 0000010 0C000010", i, decoded_instr, target26, ir_out);
         end
      end
   endtask

   task automatic test_zero_is_sll;
      drive(1'b0, 1'b1, 1'b1, 32'h00000000);
      checks++;
      if (decoded_instr !== (54'h1 << 10) || illegal_instr !== 1'b0) begin
         errors++;
         $display("FAIL zero_sll got dec=%h ill=%b exp bit10 0", decoded_instr, illegal_instr);
      end
   endtask

   task automatic test_reset_mid;
      drive(1'b0, 1'b1, 1'b1, legal_word(23));
      drive(1'b1, 1'b1, 1'b1, legal_word(5));
      checks++;
      if ({ir_out, decoded_instr, decoded_valid, illegal_instr, target26} !== '0) begin
         errors++;
         $display("FAIL reset_mid got ir=%h dec=%h v=%b exp all zero", ir_out, decoded_instr, decoded_valid);
      end
      drive(1'b0, 1'b1, 1'b0, legal_word(7));
      checks++;
      if (decoded_valid !== 1'b0 || decoded_instr !== 54'h0) begin
         errors++;
         $display("FAIL reset_mid_valid got v=%b dec=%h exp 0 0", decoded_valid, decoded_instr);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         logic [31:0] w;
         w = ($urandom_range(0, 9) < 7) ? legal_word($urandom_range(0, 53)) : $urandom;
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, w);
         checks++;
         if ({ir_out, decoded_instr, decoded_valid, illegal_instr} !== {m_ir, m_dec, m_valid, m_ill}
             || {rs, rt, rd, shamt, imm16, target26} !==
                {m_src[25:21], m_src[20:16], m_src[15:11], m_src[10:6], m_src[15:0], m_src[25:0]}) begin
            errors++;
            $display("FAIL random_%0d got ir=%h dec=%h v=%b ill=%b t26=%h exp ir=%h dec=%h v=%b ill=%b t26=%h",
                     i, ir_out, decoded_instr, decoded_valid, illegal_instr, target26,
                     m_ir, m_dec, m_valid, m_ill, m_src[25:0]);
         end
         checks++;
         if ($countones(decoded_instr) > 1) begin
            errors++;
            $display("FAIL random_onehot_%0d got dec=%h exp at most one bit", i, decoded_instr);
         end
`ifdef DECODER_STATS_EN
         checks++;
         if (instr_count !== m_icnt || illegal_count !== m_lcnt) begin
            errors++;
            $display("FAIL random_counts_%0d got %0d/%0d exp %0d/%0d", i, instr_count, illegal_count, m_icnt, m_lcnt);
         end
`endif
      end
   endtask

   task automatic test_all_encodings;
      for (int k = 0; k < 54; k++) begin
         drive(1'b0, 1'b1, 1'b1, legal_word(k));
         checks++;
         if (decoded_instr !== (54'h1 << k) || illegal_instr !== 1'b0) begin
            errors++;
            $display("FAIL encoding_%0d got dec=%h ill=%b exp one bit at %0d", k, decoded_instr, illegal_instr, k);
         end
      end
   endtask

   initial begin
      rst = 1'b1; ir_in = 1'b0; decode_ena = 1'b0; instr_in = 32'h0;
      m_ir = 32'h0; m_src = 32'h0; m_dec = '0; m_valid = 1'b0; m_ill = 1'b0;
      m_icnt = 0; m_lcnt = 0;
      test_reset;
      test_bypass;
      test_jr_lh;
      test_illegal;
      test_hold_split;
      test_zero_is_sll;
      test_reset_mid;
      test_all_encodings;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
